// File: rtl/traffic_sched_3v_pkg.sv
// Shared phase encoding and approach indices for the three-approach
// intersection controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2
   } phase_t;

   localparam logic [1:0] APP_A = 2'd0;
   localparam logic [1:0] APP_B = 2'd1;
   localparam logic [1:0] APP_C = 2'd2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/traffic_sched_3v_rr_pick.sv
// Round-robin selector: first requesting approach after cur, never cur itself.
module traffic_rr_pick (
   input  logic [2:0] req,
   input  logic [1:0] cur,
   output logic [1:0] nxt,
   output logic       valid
);
   import traffic_pkg::*;

   logic [1:0] cand1;
   logic [1:0] cand2;

   always_comb begin
      cand1 = APP_B;
      cand2 = APP_C;
      case (cur)
         APP_B: begin
            cand1 = APP_C;
            cand2 = APP_A;
         end
         APP_C: begin
            cand1 = APP_A;
            cand2 = APP_B;
         end
         default: begin
            cand1 = APP_B;
            cand2 = APP_C;
         end
      endcase

      nxt   = cur;
      valid = 1'b0;
      if (req[cand1]) begin
         nxt   = cand1;
         valid = 1'b1;
      end else if (req[cand2]) begin
         nxt   = cand2;
         valid = 1'b1;
      end
   end

endmodule

// File: rtl/traffic_sched_3v.sv
// Green/yellow/all-red phase controller for approaches A, B, C with minimum and
// maximum green, home return to A, and Moore lamp decode from state.
module traffic_sched_3v #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 2,
   parameter int ALL_RED_T = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] ABC,
   output logic       VDA,
   output logic       VDB,
   output logic       VDC,
   output logic       VAA,
   output logic       VAB,
   output logic       VAC,
   output logic       VMA,
   output logic       VMB,
   output logic       VMC,
   output logic [1:0] phase,
   output logic [1:0] cur
);
   import traffic_pkg::*;

   localparam int TW = $clog2(max3(GREEN_MAX, YELLOW_T, ALL_RED_T) + 1);
   localparam logic [TW-1:0] G_MIN_LAST = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] G_MAX_LAST = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] Y_LAST     = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] AR_LAST    = TW'((ALL_RED_T > 0) ? ALL_RED_T - 1 : 0);

   phase_t        ph;
   logic [1:0]    cur_q;
   logic [1:0]    nxt_q;
   logic [TW-1:0] timer;

   logic [2:0] req;
   logic [2:0] cur_mask;
   logic       cur_req;
   logic       other_req;
   logic       leave_a;
   logic       leave_b;
   logic       leave;
   logic       illegal;
   logic [1:0] pick;
   logic       pick_valid;

   // Sensors re-ordered so that req[i] belongs to approach index i.
   assign req       = {ABC[0], ABC[1], ABC[2]};
   assign cur_mask  = 3'b001 << cur_q;
   assign cur_req   = |(req & cur_mask);
   assign other_req = |(req & ~cur_mask);
   assign leave_a   = other_req && (!cur_req || (timer == G_MAX_LAST));
   assign leave_b   = (req == 3'b000) && (cur_q != APP_A);
   assign leave     = (timer >= G_MIN_LAST) && (leave_a || leave_b);
   assign illegal   = (cur_q == 2'd3) || (nxt_q == 2'd3) ||
                      !(ph inside {PH_GREEN, PH_YELLOW, PH_ALLRED});

   traffic_rr_pick u_pick (
      .req   (req),
      .cur   (cur_q),
      .nxt   (pick),
      .valid (pick_valid)
   );

   // The target approach is frozen at the leave decision; sensor activity
   // during yellow/all-red cannot redirect it.
   always_ff @(posedge clk) begin
      if (reset || illegal) begin
         ph    <= PH_GREEN;
         cur_q <= APP_A;
         nxt_q <= APP_A;
         timer <= '0;
      end else begin
         case (ph)
            PH_GREEN: begin
               if (leave) begin
                  nxt_q <= (leave_a && pick_valid) ? pick : APP_A;
                  ph    <= PH_YELLOW;
                  timer <= '0;
               end else if (timer != G_MAX_LAST) begin
                  timer <= timer + 1'b1;
               end
            end
            PH_YELLOW: begin
               if (timer == Y_LAST) begin
                  timer <= '0;
                  if (ALL_RED_T == 0) begin
                     ph    <= PH_GREEN;
                     cur_q <= nxt_q;
                  end else begin
                     ph <= PH_ALLRED;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PH_ALLRED: begin
               if (timer == AR_LAST) begin
                  ph    <= PH_GREEN;
                  cur_q <= nxt_q;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               ph    <= PH_GREEN;
               cur_q <= APP_A;
               nxt_q <= APP_A;
               timer <= '0;
            end
         endcase
      end
   end

   assign phase = ph;
   assign cur   = cur_q;

   assign VDA = (ph == PH_GREEN)  && cur_mask[0];
   assign VDB = (ph == PH_GREEN)  && cur_mask[1];
   assign VDC = (ph == PH_GREEN)  && cur_mask[2];
   assign VAA = (ph == PH_YELLOW) && cur_mask[0];
   assign VAB = (ph == PH_YELLOW) && cur_mask[1];
   assign VAC = (ph == PH_YELLOW) && cur_mask[2];
   assign VMA = !(VDA || VAA);
   assign VMB = !(VDB || VAB);
   assign VMC = !(VDC || VAC);

endmodule

// File: tb/tb_traffic_sched_3v.sv
// Scoreboard bench for traffic_sched_3v: each driven cycle queues the expected
// phase/cur/lamp picture, which is checked at the following falling edge.
module tb_traffic_sched_3v;

   localparam int G = 0;
   localparam int Y = 1;
   localparam int R = 2;
   localparam int A_ = 0;
   localparam int B_ = 1;
   localparam int C_ = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] ABC;
   logic       VDA, VDB, VDC, VAA, VAB, VAC, VMA, VMB, VMC;
   logic [1:0] phase;
   logic [1:0] cur;

   typedef struct {
      string       tag;
      logic [12:0] vec;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   traffic_sched_3v dut (
      .clk   (clk),
      .reset (reset),
      .ABC   (ABC),
      .VDA   (VDA),
      .VDB   (VDB),
      .VDC   (VDC),
      .VAA   (VAA),
      .VAB   (VAB),
      .VAC   (VAC),
      .VMA   (VMA),
      .VMB   (VMB),
      .VMC   (VMC),
      .phase (phase),
      .cur   (cur)
   );

   always #5 clk = ~clk;

   // Lamp triple {green, yellow, red} for approach i.
   function automatic logic [2:0] lampOf(input int ph, input int cu, input int i);
      if (ph == G && i == cu) return 3'b100;
      if (ph == Y && i == cu) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [12:0] expVec(input int ph, input int cu);
      return {2'(ph), 2'(cu), lampOf(ph, cu, 0), lampOf(ph, cu, 1), lampOf(ph, cu, 2)};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [12:0] obs;
      logic [2:0]  ok;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = {phase, cur, VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC};
         ok  = {($countones({VDA, VAA, VMA}) == 1),
                ($countones({VDB, VAB, VMB}) == 1),
                ($countones({VDC, VAC, VMC}) == 1)};
         checkOutput(e.tag, {3'b000, obs}, {3'b000, e.vec});
         checkOutput({e.tag, "_onelamp"}, {13'b0, ok}, 16'h0007);
      end
   end

   task automatic applyStimulus(input logic [2:0] abc, input logic rst,
                                input int ph, input int cu, input string tag);
      exp_t e;
      ABC   = abc;
      reset = rst;
      e.tag = tag;
      e.vec = expVec(ph, cu);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic runCycles(input logic [2:0] abc, input int n,
                            input int ph, input int cu, input string name);
      for (int i = 0; i < n; i++) begin
         applyStimulus(abc, 1'b0, ph, cu, $sformatf("%s_c%0d", name, cyc));
         cyc++;
      end
   endtask

   task automatic doReset(input logic [2:0] abc);
      reset = 1'b1;
      ABC   = abc;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   initial begin
      reset = 1'b1;
      ABC   = 3'b111;

      // No demand: A keeps green forever.
      doReset(3'b111);
      runCycles(3'b000, 50, G, A_, "idle");

      // Only B waiting: leave at minimum green.
      doReset(3'b111);
      runCycles(3'b010, 4, G, A_, "bonly");
      runCycles(3'b010, 2, Y, A_, "bonly");
      runCycles(3'b010, 1, R, A_, "bonly");
      runCycles(3'b010, 2, G, B_, "bonly");

      // A and B contend: forced off at max green, then RR to C, then home return.
      doReset(3'b111);
      runCycles(3'b110, 10, G, A_, "chain");
      runCycles(3'b110, 2,  Y, A_, "chain");
      runCycles(3'b110, 1,  R, A_, "chain");
      runCycles(3'b101, 4,  G, B_, "chain");
      runCycles(3'b000, 2,  Y, B_, "chain");
      runCycles(3'b000, 1,  R, B_, "chain");
      runCycles(3'b000, 4,  G, C_, "chain");
      runCycles(3'b000, 2,  Y, C_, "chain");
      runCycles(3'b000, 1,  R, C_, "chain");
      runCycles(3'b000, 2,  G, A_, "chain");

      // Reset sampled while yellow: restarts green on A with a fresh timer.
      doReset(3'b111);
      runCycles(3'b010, 4, G, A_, "yrst");
      applyStimulus(3'b010, 1'b1, Y, A_, "yrst_assert");
      cyc = 0;
      runCycles(3'b010, 4, G, A_, "yrst_after");
      runCycles(3'b010, 1, Y, A_, "yrst_after");

      @(negedge clk);
      if (sb.size() != 0) begin
         checkOutput("sb_drain", 16'(sb.size()), 16'h0000);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
